rx_frame_ack: RTL and testbench
===============================

RX_FRAME_ACK -- requirements
Module: rx_frame_ack

Interface
REQ-001 SHALL have parameter FRAME_BYTES, default 4164: bytes per frame, including the 6 FAS bytes and the final checksum byte.
REQ-002 SHALL have parameter BIT_TICKS, default 20: i_sclk_en_16_x_baud pulses per serial bit.
REQ-003 SHALL have parameter SAMPLE_TICK, default 9: bit-phase value at which a bit is sampled.
REQ-004 SHALL have parameter ACK_GAP, default 4: idle-high bit periods between frame end and the ACK start bit.
REQ-005 SHALL have port i_clk, input, 1 bit: system clock.
REQ-006 SHALL have port i_rst, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have port i_sclk_en_16_x_baud, input, 1 bit: tick enable, one i_clk cycle wide.
REQ-008 SHALL have port i_otn_rx_data, input, 1 bit: asynchronous serial frame stream, LSB first, no start/stop bits.
REQ-009 SHALL have port i_arq_en, input, 1 bit: 1 = send an ACK after each frame.
REQ-010 SHALL have port o_otn_tx_ack, output, 1 bit: serial ACK line, idle high.
REQ-011 SHALL have port o_data, output, 8 bits: received payload byte.
REQ-012 SHALL have port o_data_valid, output, 1 bit: one-cycle strobe qualifying o_data.
REQ-013 SHALL have port o_frame_start, output, 1 bit: one-cycle pulse on FAS lock.
REQ-014 SHALL have port o_frame_done, output, 1 bit: one-cycle pulse at frame end.
REQ-015 SHALL have port o_frame_good, output, 1 bit: checksum result, valid with o_frame_done and held until the next o_frame_done.
REQ-016 SHALL have port o_rx_state, output, 3 bits: current state encoding.

Function
REQ-017 SHALL pass i_otn_rx_data through a 2-flop synchronizer clocked every i_clk; all later logic SHALL use the synchronized copy.
REQ-018 SHALL keep a bit-phase counter 0..BIT_TICKS-1 that advances on each tick, wraps to 0, and in HUNT/RECV is forced to 0 on any synchronized input edge.
REQ-019 SHALL sample a bit when phase==SAMPLE_TICK and the tick is high.
REQ-020 States SHALL be HUNT=0, RECV=1, CHECK=2, ACK_GAP=3, ACK_START=4, ACK_BIT=5, ACK_STOP=6; any other encoding SHALL return to HUNT.
REQ-021 In HUNT, each sampled bit SHALL shift into a 48-bit register at the MSB (right shift).
REQ-022 HUNT SHALL lock when that register equals 48'h282828F6F6F6 (F6 F6 F6 28 28 28 in arrival order): pulse o_frame_start, set byte count=6, bit count=0, clear checksum, enter RECV.
REQ-023 In RECV, bits SHALL assemble LSB first; the 8th bit completes a byte, and o_data/o_data_valid SHALL be presented in the following cycle.
REQ-024 Byte count SHALL be 13 bits and increment per completed byte.
REQ-025 Bytes with index 6..FRAME_BYTES-2 SHALL be XOR-accumulated into the 8-bit checksum.
REQ-026 Byte FRAME_BYTES-1 SHALL be output and compared, not accumulated; completing it SHALL enter CHECK.
REQ-027 CHECK SHALL last one cycle: pulse o_frame_done, set o_frame_good=(checksum==last byte), then enter ACK_GAP if i_arq_en, else HUNT.
REQ-028 ACK_GAP SHALL hold o_otn_tx_ack=1 for ACK_GAP full bit periods, timed by a phase counter restarted at entry.
REQ-029 ACK_START, ACK_BIT and ACK_STOP SHALL each last exactly BIT_TICKS ticks, driving 0, o_frame_good and 0 respectively, then return to HUNT with o_otn_tx_ack=1.
REQ-030 o_otn_tx_ack SHALL be registered and SHALL be 1 in every state other than ACK_START, ACK_BIT and ACK_STOP.
REQ-031 While in CHECK or any ACK state, i_otn_rx_data SHALL be ignored.
REQ-032 The 48-bit hunt register SHALL be cleared on entry to HUNT.
REQ-033 A change of i_arq_en SHALL take effect only at CHECK; an ACK already in progress SHALL complete.
REQ-034 The block SHALL NOT re-hunt mid-frame; FAS patterns appearing in the payload SHALL be treated as data.

Reset
REQ-035 On i_rst (synchronous, active-high, taking priority over all else, including mid-frame or mid-ACK): state=HUNT; all counters, shift registers and checksum=0; o_otn_tx_ack=1; o_data=0; o_data_valid=0; o_frame_start=0; o_frame_done=0; o_frame_good=0; synchronizer flops=1.
REQ-036 The first tick after reset release SHALL be treated as phase 0.

Verification
REQ-037 Good frame: serialize a full FRAME_BYTES frame with a correct XOR byte, i_arq_en=1 -> o_frame_start once, 4158 o_data_valid strobes in order, o_frame_good=1, ACK waveform 1(gap 80 ticks), 0, 1, 0 at 20 ticks each, then idle 1.
REQ-038 Bad checksum: same frame with byte 100 flipped -> o_frame_good=0; ACK bit=0.
REQ-039 ARQ off: i_arq_en=0 -> o_frame_done pulses; o_otn_tx_ack stays 1 throughout; state returns to HUNT the cycle after CHECK.
REQ-040 Misaligned hunt: 13 random bits followed by FAS and frame -> lock only on the true FAS; first o_data equals byte 6; payload containing F6F6F6282828 does not restart the frame.
REQ-041 Reset mid-frame: assert i_rst at byte 2000 -> next cycle state=0 and o_otn_tx_ack=1; a new frame afterwards is received good.
REQ-042 Phase drift: source bit period alternating 19 and 21 ticks -> edge resync keeps all bytes correct; o_frame_good=1.

Source files
------------

// File: rtl/rx_frame_ack_if.sv
// rx_frame_ack_if
//   Receive-side payload bus of rx_frame_ack.
//   o_data        : received payload byte
//   o_data_valid  : one-cycle strobe qualifying o_data
//   o_frame_start : one-cycle pulse when the frame alignment word locks
//   o_frame_done  : one-cycle pulse at frame end
//   o_frame_good  : checksum verdict, valid with o_frame_done, held until the next one
//   master modport drives the bus (the receiver), slave modport consumes it.
interface rx_frame_ack_if;
  logic [7:0] o_data;
  logic       o_data_valid;
  logic       o_frame_start;
  logic       o_frame_done;
  logic       o_frame_good;

  modport master (
    output o_data,
    output o_data_valid,
    output o_frame_start,
    output o_frame_done,
    output o_frame_good
  );

  modport slave (
    input o_data,
    input o_data_valid,
    input o_frame_start,
    input o_frame_done,
    input o_frame_good
  );
endinterface

// File: rtl/rx_frame_ack.sv
// rx_frame_ack
//   Serial frame receiver with optional one-bit ACK reply.
//   Hunts for the 48-bit alignment word F6 F6 F6 28 28 28 in an LSB-first stream
//   with no start/stop bits, delivers every following byte, XOR-checks the frame
//   against its last byte and, when ARQ is enabled, answers on o_otn_tx_ack with
//   an idle gap, a start bit (0), the verdict bit and a stop bit (0).
//   Ports:
//     i_clk, i_rst          : clock, synchronous active-high reset
//     i_sclk_en_16_x_baud   : one-cycle tick enable, BIT_TICKS ticks per bit
//     i_otn_rx_data         : asynchronous serial input
//     i_arq_en              : 1 = reply with an ACK after each frame
//     o_otn_tx_ack          : serial ACK line, idle high
//     o_rx_state            : current state encoding
//     rx_if (master)        : payload byte / strobe / frame pulses / verdict
module rx_frame_ack #(
  parameter int FRAME_BYTES = 4164,
  parameter int BIT_TICKS   = 20,
  parameter int SAMPLE_TICK = 9,
  parameter int ACK_GAP     = 4
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_sclk_en_16_x_baud,
  input  logic           i_otn_rx_data,
  input  logic           i_arq_en,
  output logic           o_otn_tx_ack,
  output logic [2:0]     o_rx_state,
  rx_frame_ack_if.master rx_if
);
  localparam int              PW        = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
  localparam logic [PW-1:0]   PH_LAST   = PW'(BIT_TICKS - 1);
  localparam logic [PW-1:0]   PH_SAMPLE = PW'(SAMPLE_TICK);
  localparam logic [PW-1:0]   PH_ZERO   = {PW{1'b0}};
  localparam logic [PW-1:0]   PH_ONE    = PW'(1);
  localparam logic [7:0]      GAP_LAST  = 8'(ACK_GAP - 1);
  localparam logic [12:0]     BYTE_LAST = 13'(FRAME_BYTES - 1);
  localparam logic [47:0]     FAS_WORD  = 48'h2828_28F6_F6F6;

  typedef enum logic [2:0] {
    ST_HUNT      = 3'd0,
    ST_RECV      = 3'd1,
    ST_CHECK     = 3'd2,
    ST_ACK_GAP   = 3'd3,
    ST_ACK_START = 3'd4,
    ST_ACK_BIT   = 3'd5,
    ST_ACK_STOP  = 3'd6
  } state_t;

  // Running XOR checksum step.
  function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  state_t        state_q, state_d;
  logic          sync1_q, sync2_q, prev_q;
  logic [PW-1:0] phase_q, phase_d;
  logic [47:0]   hunt_q, hunt_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [12:0]   byte_cnt_q, byte_cnt_d;
  logic [7:0]    csum_q, csum_d;
  logic [7:0]    gap_cnt_q, gap_cnt_d;
  logic          ack_q, ack_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          start_q, start_d;
  logic          done_q, done_d;
  logic          good_q, good_d;
  logic          phase_clr_s;

  logic          edge_s, sample_s, bit_end_s;
  logic [7:0]    byte_s;
  logic [47:0]   hunt_s;

  assign edge_s    = sync2_q ^ prev_q;
  assign sample_s  = i_sclk_en_16_x_baud && (phase_q == PH_SAMPLE);
  assign bit_end_s = i_sclk_en_16_x_baud && (phase_q == PH_LAST);
  assign byte_s    = {sync2_q, shift_q[7:1]};
  assign hunt_s    = {sync2_q, hunt_q[47:1]};

  // Bit-phase counter: free-running on ticks, pulled to zero by input edges while receiving.
  always_comb begin
    phase_d = phase_q;
    if ((state_q == ST_HUNT || state_q == ST_RECV) && edge_s) begin
      phase_d = PH_ZERO;
    end else if (phase_clr_s) begin
      phase_d = PH_ZERO;
    end else if (i_sclk_en_16_x_baud) begin
      phase_d = (phase_q == PH_LAST) ? PH_ZERO : phase_q + PH_ONE;
    end else begin
      phase_d = phase_q;
    end
  end

  // Frame FSM and datapath next-state logic.
  always_comb begin
    state_d     = state_q;
    hunt_d      = hunt_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    csum_d      = csum_q;
    gap_cnt_d   = gap_cnt_q;
    data_d      = data_q;
    good_d      = good_q;
    ack_d       = 1'b1;
    valid_d     = 1'b0;
    start_d     = 1'b0;
    done_d      = 1'b0;
    phase_clr_s = 1'b0;
    case (state_q)
      ST_HUNT: begin
        if (sample_s) begin
          // Compare the word including the bit being sampled so lock lands on the last FAS bit.
          if (hunt_s == FAS_WORD) begin
            start_d    = 1'b1;
            byte_cnt_d = 13'd6;
            bit_cnt_d  = 3'd0;
            csum_d     = 8'h00;
            hunt_d     = 48'h0;
            state_d    = ST_RECV;
          end else begin
            hunt_d = hunt_s;
          end
        end else begin
          hunt_d = hunt_q;
        end
      end
      ST_RECV: begin
        if (sample_s) begin
          shift_d   = byte_s;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            data_d     = byte_s;
            valid_d    = 1'b1;
            byte_cnt_d = byte_cnt_q + 13'd1;
            // The final byte carries the expected checksum, so it is not folded in.
            if (byte_cnt_q == BYTE_LAST) begin
              state_d = ST_CHECK;
            end else begin
              csum_d = csum_step(csum_q, byte_s);
            end
          end else begin
            data_d = data_q;
          end
        end else begin
          shift_d = shift_q;
        end
      end
      ST_CHECK: begin
        done_d = 1'b1;
        good_d = (csum_q == data_q);
        if (i_arq_en) begin
          state_d     = ST_ACK_GAP;
          gap_cnt_d   = 8'd0;
          phase_clr_s = 1'b1;
        end else begin
          state_d = ST_HUNT;
          hunt_d  = 48'h0;
        end
      end
      ST_ACK_GAP: begin
        if (bit_end_s) begin
          if (gap_cnt_q == GAP_LAST) begin
            state_d = ST_ACK_START;
            ack_d   = 1'b0;
          end else begin
            gap_cnt_d = gap_cnt_q + 8'd1;
          end
        end else begin
          gap_cnt_d = gap_cnt_q;
        end
      end
      ST_ACK_START: begin
        if (bit_end_s) begin
          state_d = ST_ACK_BIT;
          ack_d   = good_q;
        end else begin
          ack_d = 1'b0;
        end
      end
      ST_ACK_BIT: begin
        if (bit_end_s) begin
          state_d = ST_ACK_STOP;
          ack_d   = 1'b0;
        end else begin
          ack_d = good_q;
        end
      end
      ST_ACK_STOP: begin
        if (bit_end_s) begin
          state_d = ST_HUNT;
          hunt_d  = 48'h0;
          ack_d   = 1'b1;
        end else begin
          ack_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_HUNT;
        hunt_d  = 48'h0;
        ack_d   = 1'b1;
      end
    endcase
  end

  // Two-flop synchronizer and edge-detect history for the serial input.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= i_otn_rx_data;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // State, counter, datapath and output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_HUNT;
      phase_q    <= PH_ZERO;
      hunt_q     <= 48'h0;
      shift_q    <= 8'h00;
      bit_cnt_q  <= 3'd0;
      byte_cnt_q <= 13'd0;
      csum_q     <= 8'h00;
      gap_cnt_q  <= 8'd0;
      ack_q      <= 1'b1;
      data_q     <= 8'h00;
      valid_q    <= 1'b0;
      start_q    <= 1'b0;
      done_q     <= 1'b0;
      good_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      hunt_q     <= hunt_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      csum_q     <= csum_d;
      gap_cnt_q  <= gap_cnt_d;
      ack_q      <= ack_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      start_q    <= start_d;
      done_q     <= done_d;
      good_q     <= good_d;
    end
  end

  assign o_otn_tx_ack        = ack_q;
  assign o_rx_state          = state_q;
  assign rx_if.o_data        = data_q;
  assign rx_if.o_data_valid  = valid_q;
  assign rx_if.o_frame_start = start_q;
  assign rx_if.o_frame_done  = done_q;
  assign rx_if.o_frame_good  = good_q;
endmodule

// File: tb/tb_rx_frame_ack.sv
// tb_rx_frame_ack
//   Directed scenarios with random payloads for rx_frame_ack (shortened frame).
//   Expected bytes, checksum verdict and ACK waveform come from the frame
//   contents and the protocol rules, not from the design.
module tb_rx_frame_ack;
  localparam int FB      = 20;
  localparam int BT      = 20;
  localparam int AGAP    = 4;
  localparam int ACK_LEN = 150;
  localparam logic [7:0] FAS_SEQ [6] = '{8'hF6, 8'hF6, 8'hF6, 8'h28, 8'h28, 8'h28};

  logic       clk = 1'b0;
  logic       rst, tick, rx, arq, ack;
  logic [2:0] state;

  rx_frame_ack_if rx_if ();

  rx_frame_ack #(
    .FRAME_BYTES(FB), .BIT_TICKS(BT), .SAMPLE_TICK(9), .ACK_GAP(AGAP)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_sclk_en_16_x_baud(tick), .i_otn_rx_data(rx),
    .i_arq_en(arq), .o_otn_tx_ack(ack), .o_rx_state(state), .rx_if(rx_if)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  logic [7:0] got_q [$];
  logic       ack_log [$];
  logic       ack_watch = 1'b0;
  int         start_cnt = 0;
  int         done_cnt = 0;
  int         ack_low = 0;
  logic [2:0] done_state = 3'd7;
  logic       done_good = 1'b0;
  logic [7:0] frame [FB];
  bit         drift = 1'b0;
  bit         slow = 1'b0;

  // Output monitor, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rx_if.o_data_valid === 1'b1) got_q.push_back(rx_if.o_data);
      if (rx_if.o_frame_start === 1'b1) start_cnt++;
      if (rx_if.o_frame_done === 1'b1) begin
        done_cnt++;
        done_state = state;
        done_good  = rx_if.o_frame_good;
        ack_log.delete();
        ack_watch = 1'b1;
      end
      if (ack_watch && tick === 1'b1) begin
        ack_log.push_back(ack);
        if (ack_log.size() >= ACK_LEN) ack_watch = 1'b0;
      end
      if (ack === 1'b0) ack_low++;
    end
  end

  // Watchdog.
  initial begin
    #10000000;
    $display("FAIL watchdog: run exceeded its time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total = total + 1;
    assert (obs === want) else begin
      bad = bad + 1;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // One tick period: two clocks, tick high for the second.
  task automatic tk();
    @(posedge clk); #1 tick = 1'b1;
    @(posedge clk); #1 tick = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    int n;
    if (drift) begin
      n = slow ? BT + 1 : BT - 1;
      slow = ~slow;
    end else begin
      n = BT;
    end
    rx = b;
    repeat (n) tk();
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
  endtask

  task automatic build_frame(input int flip_idx, input bit fas_payload);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < 6; i++) frame[i] = FAS_SEQ[i];
    for (int i = 6; i < FB - 1; i++) frame[i] = 8'($urandom);
    if (fas_payload) for (int i = 0; i < 6; i++) frame[8 + i] = FAS_SEQ[i];
    for (int i = 6; i < FB - 1; i++) x = x ^ frame[i];
    frame[FB - 1] = x;
    if (flip_idx >= 0) frame[flip_idx] = ~frame[flip_idx];
  endtask

  task automatic run_frame(input string name, input bit arq_v, input int flip_idx,
                           input bit drift_v, input int pre_bits, input bit fas_payload,
                           input bit drop_arq);
    logic [7:0]  x;
    logic        exp_good;
    logic        exp_ack;
    logic [31:0] obs;
    int          mism;
    int          low0;
    build_frame(flip_idx, fas_payload);
    x = 8'h00;
    for (int i = 6; i < FB - 1; i++) x = x ^ frame[i];
    exp_good = (x == frame[FB - 1]);
    arq = arq_v;
    drift = drift_v;
    got_q.delete();
    start_cnt = 0;
    done_cnt = 0;
    low0 = ack_low;
    for (int i = 0; i < pre_bits; i++) send_bit(1'($urandom));
    for (int i = 0; i < FB; i++) send_byte(frame[i]);
    rx = 1'b1;
    if (drop_arq) arq = 1'b0;
    for (int i = 0; i < 400 && (done_cnt == 0 || ack_watch); i++) tk();
    @(negedge clk);
    check({name, "_start"}, start_cnt, 1);
    check({name, "_nbytes"}, got_q.size(), FB - 6);
    for (int i = 6; i < FB; i++) begin
      if (i - 6 < got_q.size()) obs = {24'd0, got_q[i - 6]};
      else obs = 32'h100;
      check({name, "_byte"}, obs, {24'd0, frame[i]});
    end
    check({name, "_done"}, done_cnt, 1);
    check({name, "_good"}, done_good, exp_good);
    check({name, "_state_after_check"}, done_state, arq_v ? 3 : 0);
    check({name, "_good_hold"}, rx_if.o_frame_good, exp_good);
    check({name, "_acklog_len"}, ack_log.size(), ACK_LEN);
    mism = 0;
    for (int k = 1; k <= ACK_LEN; k++) begin
      if (!arq_v) exp_ack = 1'b1;
      else if (k <= AGAP * BT) exp_ack = 1'b1;
      else if (k <= AGAP * BT + BT) exp_ack = 1'b0;
      else if (k <= AGAP * BT + 2 * BT) exp_ack = exp_good;
      else if (k <= AGAP * BT + 3 * BT) exp_ack = 1'b0;
      else exp_ack = 1'b1;
      if (k - 1 < ack_log.size()) begin
        if (ack_log[k - 1] !== exp_ack) mism++;
      end
    end
    check({name, "_ack_wave"}, mism, 0);
    // Clock cycles with the line low: each low bit is BT ticks of two clocks.
    check({name, "_ack_low_cycles"}, ack_low - low0, arq_v ? (exp_good ? 2 : 3) * BT * 2 : 0);
    drift = 1'b0;
    arq = 1'b1;
    repeat (5) tk();
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; rx = 1'b1; arq = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_state", state, 0);
    check("rst_ack", ack, 1);
    check("rst_data", rx_if.o_data, 0);
    check("rst_valid", rx_if.o_data_valid, 0);
    check("rst_start", rx_if.o_frame_start, 0);
    check("rst_done", rx_if.o_frame_done, 0);
    check("rst_good", rx_if.o_frame_good, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) tk();

    run_frame("good", 1'b1, -1, 1'b0, 0, 1'b0, 1'b0);
    run_frame("badsum", 1'b1, 10, 1'b0, 0, 1'b0, 1'b1);
    run_frame("arq_off", 1'b0, -1, 1'b0, 0, 1'b0, 1'b0);
    run_frame("misalign", 1'b1, -1, 1'b0, 13, 1'b1, 1'b0);

    // Reset in the middle of a frame.
    build_frame(-1, 1'b0);
    for (int i = 0; i < 12; i++) send_byte(frame[i]);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check("midrst_state", state, 0);
    check("midrst_ack", ack, 1);
    check("midrst_good", rx_if.o_frame_good, 0);
    check("midrst_data", rx_if.o_data, 0);
    @(posedge clk); #1 rst = 1'b0; rx = 1'b1;
    repeat (5) tk();
    run_frame("after_rst", 1'b1, -1, 1'b0, 0, 1'b0, 1'b0);

    run_frame("drift", 1'b1, -1, 1'b1, 0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
